// File: rtl/debug_unit.sv
// rtl/debug_unit.sv - MIPS pipeline debug controller: host command decode, program load, run/step, state dump
module debug_unit #(
    parameter int NB_IF_ID    = 64,
    parameter int NB_ID_EX    = 139,
    parameter int NB_EX_MEM   = 76,
    parameter int NB_MEM_WB   = 71,
    parameter int N_REGS      = 32,
    parameter int N_MEM_WORDS = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_rx_valid,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_start,
    input  logic                 i_tx_done,
    input  logic                 i_end_of_program,
    output logic                 o_halt,
    output logic                 o_write_instruction_mem,
    output logic [31:0]          o_instruction_mem_addr,
    output logic [31:0]          o_instruction_mem_data,
    output logic [4:0]           o_r_addr_registers,
    input  logic [31:0]          i_r_data_registers,
    output logic [4:0]           o_r_addr_data_mem,
    input  logic [31:0]          i_r_data_data_mem,
    input  logic [NB_IF_ID-1:0]  i_IF_ID,
    input  logic [NB_ID_EX-1:0]  i_ID_EX,
    input  logic [NB_EX_MEM-1:0] i_EX_MEM,
    input  logic [NB_MEM_WB-1:0] i_MEM_WB
);

    localparam int W_IF_ID  = 8 * ((NB_IF_ID + 7) / 8);
    localparam int W_ID_EX  = 8 * ((NB_ID_EX + 7) / 8);
    localparam int W_EX_MEM = 8 * ((NB_EX_MEM + 7) / 8);
    localparam int W_MEM_WB = 8 * ((NB_MEM_WB + 7) / 8);
    localparam int NB_SNAP  = W_IF_ID + W_ID_EX + W_EX_MEM + W_MEM_WB;
    localparam int N_LATCH_BYTES = NB_SNAP / 8;
    localparam logic [5:0] LAST_LATCH_BYTE = 6'(N_LATCH_BYTES - 1);
    localparam logic [4:0] LAST_REG        = 5'(N_REGS - 1);
    localparam logic [4:0] LAST_MEM_WORD   = 5'(N_MEM_WORDS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_COUNT, S_LOAD_DATA, S_ACK, S_RUN, S_STEP,
        S_SNAP, S_LATCH, S_WORD_WAIT, S_WORD_CAP, S_WORD_SEND
    } state_t;

    state_t state, next_state;

    logic               tx_busy;
    logic               tx_fire;
    logic [7:0]         tx_byte;
    logic [NB_SNAP-1:0] snap;
    logic [5:0]         lat_cnt;
    logic [7:0]         instr_count;
    logic [7:0]         word_idx;
    logic [1:0]         byte_cnt;
    logic [23:0]        load_word;
    logic [31:0]        dump_word;
    logic               mem_phase;

    logic [W_IF_ID-1:0]  if_id_ext;
    logic [W_ID_EX-1:0]  id_ex_ext;
    logic [W_EX_MEM-1:0] ex_mem_ext;
    logic [W_MEM_WB-1:0] mem_wb_ext;

    assign if_id_ext  = W_IF_ID'(i_IF_ID);
    assign id_ex_ext  = W_ID_EX'(i_ID_EX);
    assign ex_mem_ext = W_EX_MEM'(i_EX_MEM);
    assign mem_wb_ext = W_MEM_WB'(i_MEM_WB);

    always_ff @(posedge i_clk) begin
        if (!i_reset) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        tx_fire    = 1'b0;
        tx_byte    = 8'h00;
        case (state)
            S_IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        8'h4C:   next_state = S_LOAD_COUNT;
                        8'h43:   next_state = i_end_of_program ? S_SNAP : S_RUN;
                        8'h53:   next_state = S_STEP;
                        default: next_state = S_IDLE;
                    endcase
                end
            end
            S_LOAD_COUNT: begin
                if (i_rx_valid) next_state = (i_rx_data == 8'd0) ? S_ACK : S_LOAD_DATA;
            end
            S_LOAD_DATA: begin
                if (i_rx_valid && byte_cnt == 2'd3 && word_idx == instr_count - 8'd1)
                    next_state = S_ACK;
            end
            S_ACK: begin
                if (!tx_busy) begin
                    tx_fire    = 1'b1;
                    tx_byte    = 8'h06;
                    next_state = S_IDLE;
                end
            end
            S_RUN:  if (i_end_of_program) next_state = S_SNAP;
            S_STEP: next_state = S_SNAP;
            S_SNAP: next_state = S_LATCH;
            S_LATCH: begin
                if (!tx_busy) begin
                    tx_fire = 1'b1;
                    tx_byte = snap[NB_SNAP-1 -: 8];
                    if (lat_cnt == LAST_LATCH_BYTE) next_state = S_WORD_WAIT;
                end
            end
            S_WORD_WAIT: next_state = S_WORD_CAP;
            S_WORD_CAP:  next_state = S_WORD_SEND;
            S_WORD_SEND: begin
                if (!tx_busy) begin
                    tx_fire = 1'b1;
                    tx_byte = dump_word[31:24];
                    if (byte_cnt == 2'd3)
                        next_state = (mem_phase && o_r_addr_data_mem == LAST_MEM_WORD) ? S_IDLE : S_WORD_WAIT;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_tx_data               <= 8'h00;
            o_tx_start              <= 1'b0;
            o_halt                  <= 1'b1;
            o_write_instruction_mem <= 1'b0;
            o_instruction_mem_addr  <= 32'd0;
            o_instruction_mem_data  <= 32'd0;
            o_r_addr_registers      <= 5'd0;
            o_r_addr_data_mem       <= 5'd0;
            tx_busy                 <= 1'b0;
            snap                    <= '0;
            lat_cnt                 <= 6'd0;
            instr_count             <= 8'd0;
            word_idx                <= 8'd0;
            byte_cnt                <= 2'd0;
            load_word               <= 24'd0;
            dump_word               <= 32'd0;
            mem_phase               <= 1'b0;
        end else begin
            o_tx_start              <= 1'b0;
            o_write_instruction_mem <= 1'b0;
            o_halt                  <= !(next_state == S_RUN || next_state == S_STEP);

            // tx_fire only happens while idle, so a done strobe with nothing pending is harmless
            if (i_tx_done) tx_busy <= 1'b0;
            if (tx_fire) begin
                tx_busy    <= 1'b1;
                o_tx_start <= 1'b1;
                o_tx_data  <= tx_byte;
            end

            case (state)
                S_LOAD_COUNT: begin
                    if (i_rx_valid) begin
                        instr_count <= i_rx_data;
                        word_idx    <= 8'd0;
                        byte_cnt    <= 2'd0;
                    end
                end
                S_LOAD_DATA: begin
                    if (i_rx_valid) begin
                        load_word <= {load_word[15:0], i_rx_data};
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            o_write_instruction_mem <= 1'b1;
                            o_instruction_mem_data  <= {load_word, i_rx_data};
                            o_instruction_mem_addr  <= {22'd0, word_idx, 2'b00};
                            word_idx                <= word_idx + 8'd1;
                        end
                    end
                end
                S_SNAP: begin
                    snap    <= {if_id_ext, id_ex_ext, ex_mem_ext, mem_wb_ext};
                    lat_cnt <= 6'd0;
                end
                S_LATCH: begin
                    if (!tx_busy) begin
                        snap    <= snap << 8;
                        lat_cnt <= lat_cnt + 6'd1;
                        if (lat_cnt == LAST_LATCH_BYTE) begin
                            mem_phase          <= 1'b0;
                            o_r_addr_registers <= 5'd0;
                            o_r_addr_data_mem  <= 5'd0;
                        end
                    end
                end
                S_WORD_CAP: begin
                    dump_word <= mem_phase ? i_r_data_data_mem : i_r_data_registers;
                    byte_cnt  <= 2'd0;
                end
                S_WORD_SEND: begin
                    if (!tx_busy) begin
                        dump_word <= dump_word << 8;
                        byte_cnt  <= byte_cnt + 2'd1;
                        // mem_phase doubles as the register-pass done flag, so index 31 never wraps to 0
                        if (byte_cnt == 2'd3) begin
                            if (!mem_phase) begin
                                if (o_r_addr_registers == LAST_REG) mem_phase <= 1'b1;
                                else o_r_addr_registers <= o_r_addr_registers + 5'd1;
                            end else if (o_r_addr_data_mem != LAST_MEM_WORD) begin
                                o_r_addr_data_mem <= o_r_addr_data_mem + 5'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_unit.sv
// tb/tb_debug_unit.sv - self-checking bench for debug_unit
module tb_debug_unit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         tx_done;
    logic         eop;
    logic         halt;
    logic         wr_en;
    logic [31:0]  wr_addr;
    logic [31:0]  wr_data;
    logic [4:0]   reg_addr;
    logic [31:0]  reg_data;
    logic [4:0]   mem_addr;
    logic [31:0]  mem_data;
    logic [63:0]  if_id  = 64'h0123_4567_89AB_CDEF;
    logic [138:0] id_ex  = {11'h5A3, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF};
    logic [75:0]  ex_mem = 76'hE_0123_4567_89AB_CDEF_01;
    logic [70:0]  mem_wb = 71'h4F_0011_2233_4455_6677;

    always #5 clk = ~clk;

    function automatic logic [31:0] reg_model(input int k);
        return 32'hC0DE_0000 | (k << 8) | k;
    endfunction

    assign reg_data = reg_model(int'(reg_addr));
    assign mem_data = 32'hA500_0000 | {27'd0, mem_addr};

    debug_unit dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
        .i_end_of_program(eop), .o_halt(halt),
        .o_write_instruction_mem(wr_en), .o_instruction_mem_addr(wr_addr),
        .o_instruction_mem_data(wr_data),
        .o_r_addr_registers(reg_addr), .i_r_data_registers(reg_data),
        .o_r_addr_data_mem(mem_addr), .i_r_data_data_mem(mem_data),
        .i_IF_ID(if_id), .i_ID_EX(id_ex), .i_EX_MEM(ex_mem), .i_MEM_WB(mem_wb)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor state: written only by the monitor process, read by the test as running totals
    logic [7:0]  tx_q[$];
    logic [63:0] wr_q[$];
    int          halt_low = 0;
    int          hs_err   = 0;
    int          wr_wide  = 0;
    logic        pending  = 1'b0;
    logic        wr_prev  = 1'b0;
    logic [7:0]  cur_byte = 8'h00;
    int          cnt      = 0;

    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (!rst_n) begin
                pending = 1'b0;
                wr_prev = 1'b0;
            end else begin
                if (!halt) halt_low++;
                if (wr_en) wr_q.push_back({wr_addr, wr_data});
                if (wr_en && wr_prev) wr_wide++;
                wr_prev = wr_en;
                if (pending) begin
                    if (tx_data !== cur_byte) hs_err++;
                    cnt--;
                    if (cnt == 0) begin
                        tx_done = 1'b1;
                        pending = 1'b0;
                    end
                end
                if (tx_start) begin
                    if (pending) hs_err++;
                    tx_q.push_back(tx_data);
                    cur_byte = tx_data;
                    pending  = 1'b1;
                    cnt      = 10;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int base, input int target, input string name);
        int t = 0;
        while (!((tx_q.size() - base) >= target && !pending) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 20000) check({name, " timeout"}, 32'(tx_q.size() - base), 32'(target));
        repeat (60) @(posedge clk);
        #1;
    endtask

    logic [7:0]   exp_dump[301];
    logic [359:0] snap_exp;

    task automatic check_dump(input int base, input string name);
        check({name, " byte count"}, 32'(tx_q.size() - base), 32'd301);
        for (int i = 0; i < 301; i++)
            if (base + i < tx_q.size())
                check($sformatf("%s byte %0d", name, i), 32'(tx_q[base+i]), 32'(exp_dump[i]));
        if (base + 300 < tx_q.size()) begin
            check({name, " reg0 word"}, {tx_q[base+45], tx_q[base+46], tx_q[base+47], tx_q[base+48]}, reg_model(0));
            check({name, " last mem word"}, {tx_q[base+297], tx_q[base+298], tx_q[base+299], tx_q[base+300]}, 32'hA500_001F);
        end
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic       eop;
        int         exp_bytes;
        int         exp_halt_low;
    } cmd_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_vec_t;

    cmd_vec_t vecs[6];
    wr_vec_t  load_exp[2];
    logic [7:0] load_bytes[10];

    initial begin
        int tb, hb, wb, eb, wwb;

        vecs[0] = '{8'h7A, 1'b0, 0, 0};
        vecs[1] = '{8'h00, 1'b0, 0, 0};
        vecs[2] = '{8'hFF, 1'b0, 0, 0};
        vecs[3] = '{8'h53, 1'b0, 301, 1};
        vecs[4] = '{8'h53, 1'b1, 301, 1};
        vecs[5] = '{8'h43, 1'b1, 301, 0};
        load_exp[0] = '{32'd0, 32'h2001_0005};
        load_exp[1] = '{32'd4, 32'h0000_0000};
        load_bytes = '{8'h4C, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};

        snap_exp = {if_id, 5'b0, id_ex, 4'b0, ex_mem, 1'b0, mem_wb};
        for (int i = 0; i < 45; i++) exp_dump[i] = snap_exp[359 - 8*i -: 8];
        for (int k = 0; k < 32; k++) begin
            logic [31:0] r, m;
            r = reg_model(k);
            m = 32'hA500_0000 | k;
            for (int b = 0; b < 4; b++) begin
                exp_dump[45 + 4*k + b]  = r[31 - 8*b -: 8];
                exp_dump[173 + 4*k + b] = m[31 - 8*b -: 8];
            end
        end

        rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; eop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset halt", 32'(halt), 32'd1);
        check("reset tx_start", 32'(tx_start), 32'd0);
        check("reset write", 32'(wr_en), 32'd0);
        check("reset tx_data", 32'(tx_data), 32'd0);
        check("reset imem addr", wr_addr, 32'd0);
        check("reset imem data", wr_data, 32'd0);
        check("reset reg addr", 32'(reg_addr), 32'd0);
        check("reset mem addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 6; v++) begin
            tb = tx_q.size(); hb = halt_low; wb = wr_q.size(); eb = hs_err;
            eop = vecs[v].eop;
            send_byte(vecs[v].cmd);
            wait_bytes(tb, vecs[v].exp_bytes, $sformatf("vec%0d", v));
            check($sformatf("vec%0d tx count", v), 32'(tx_q.size() - tb), 32'(vecs[v].exp_bytes));
            check($sformatf("vec%0d halt low cycles", v), 32'(halt_low - hb), 32'(vecs[v].exp_halt_low));
            check($sformatf("vec%0d writes", v), 32'(wr_q.size() - wb), 32'd0);
            check($sformatf("vec%0d handshake", v), 32'(hs_err - eb), 32'd0);
            check($sformatf("vec%0d halt idle", v), 32'(halt), 32'd1);
            if (vecs[v].exp_bytes == 301) check_dump(tb, $sformatf("vec%0d", v));
            eop = 1'b0;
        end

        tb = tx_q.size(); wb = wr_q.size(); wwb = wr_wide;
        for (int i = 0; i < 10; i++) send_byte(load_bytes[i]);
        wait_bytes(tb, 1, "load");
        check("load write count", 32'(wr_q.size() - wb), 32'd2);
        for (int i = 0; i < 2; i++) begin
            if (wb + i < wr_q.size()) begin
                check($sformatf("load addr %0d", i), wr_q[wb+i][63:32], load_exp[i].addr);
                check($sformatf("load data %0d", i), wr_q[wb+i][31:0], load_exp[i].data);
            end
        end
        check("load strobe width", 32'(wr_wide - wwb), 32'd0);
        check("load ack count", 32'(tx_q.size() - tb), 32'd1);
        if (tx_q.size() > tb) check("load ack byte", 32'(tx_q[tb]), 32'h06);

        tb = tx_q.size(); wb = wr_q.size();
        send_byte(8'h4C);
        send_byte(8'h00);
        wait_bytes(tb, 1, "load0");
        check("load0 writes", 32'(wr_q.size() - wb), 32'd0);
        check("load0 ack count", 32'(tx_q.size() - tb), 32'd1);
        if (tx_q.size() > tb) check("load0 ack byte", 32'(tx_q[tb]), 32'h06);

        // Continuous run: end_of_program is sampled on the 20th edge after the command
        tb = tx_q.size(); hb = halt_low; eb = hs_err;
        send_byte(8'h43);
        repeat (19) @(posedge clk);
        #1 eop = 1'b1;
        repeat (30) @(posedge clk);
        send_byte(8'h43);
        wait_bytes(tb, 301, "run");
        check("run halt low cycles", 32'(halt_low - hb), 32'd20);
        check("run handshake", 32'(hs_err - eb), 32'd0);
        check_dump(tb, "run");
        eop = 1'b0;

        tb = tx_q.size();
        send_byte(8'h53);
        begin
            int t = 0;
            while ((tx_q.size() - tb) < 50 && t < 20000) begin
                @(posedge clk);
                t++;
            end
            if (t >= 20000) check("rst wait timeout", 32'(tx_q.size() - tb), 32'd50);
        end
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        tb = tx_q.size(); hb = halt_low; wb = wr_q.size();
        check("rst mid-dump halt", 32'(halt), 32'd1);
        check("rst mid-dump tx_start", 32'(tx_start), 32'd0);
        check("rst mid-dump tx_data", 32'(tx_data), 32'd0);
        check("rst mid-dump reg addr", 32'(reg_addr), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check("rst quiet tx", 32'(tx_q.size() - tb), 32'd0);
        check("rst quiet halt", 32'(halt_low - hb), 32'd0);
        check("rst quiet writes", 32'(wr_q.size() - wb), 32'd0);
        tb = tx_q.size(); eb = hs_err;
        send_byte(8'h53);
        wait_bytes(tb, 301, "post-rst step");
        check("post-rst handshake", 32'(hs_err - eb), 32'd0);
        check_dump(tb, "post-rst step");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
